// File: rtl/ff_unstuffer.sv
// JPEG entropy-coded byte unstuffer: drops the 00 after each FF and repacks the
// surviving bytes into 32-bit big-endian words.
module ff_unstuffer #(
    parameter int STUFF_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [2:0]             in_nbytes,
    output logic                   in_ready,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [2:0]             out_nbytes,
    input  logic                   out_ready,
    output logic                   marker_det,
    output logic [STUFF_CNT_W-1:0] stuff_cnt
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; valid never waits for ready, and a stalled producer holds its payload.

    logic [7:0] acc [7];
    logic [2:0] cnt;
    logic       flush;
    logic       prev_ff;

    logic [7:0] fwd [4];
    logic [2:0] fwd_cnt;
    logic [1:0] drop_cnt;
    logic       marker_hit;
    logic       prev_ff_next;
    logic [2:0] nb;

    logic       pop;
    logic       accept;
    logic [7:0] acc_n [7];
    logic [2:0] cnt_n;

    logic [STUFF_CNT_W:0]   stuff_sum;
    logic [STUFF_CNT_W-1:0] stuff_next;

    always_comb begin : filter
        logic       p;
        logic [7:0] b;
        nb = in_last ? ((in_nbytes > 3'd4) ? 3'd4 : in_nbytes) : 3'd4;
        p          = prev_ff;
        fwd_cnt    = 3'd0;
        drop_cnt   = 2'd0;
        marker_hit = 1'b0;
        b          = 8'h00;
        for (int i = 0; i < 4; i++) fwd[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b = in_data[31-8*i -: 8];
            if (3'(i) < nb) begin
                if (p && b == 8'h00) begin
                    drop_cnt = drop_cnt + 2'd1;
                    p        = 1'b0;
                end else begin
                    if (p && b != 8'hFF) marker_hit = 1'b1;
                    fwd[fwd_cnt[1:0]] = b;
                    fwd_cnt           = fwd_cnt + 3'd1;
                    p                 = (b == 8'hFF);
                end
            end
        end
        prev_ff_next = p;
    end

    assign out_valid  = flush | (cnt >= 3'd4);
    assign out_last   = flush & (cnt <= 3'd4);
    assign out_nbytes = out_last ? cnt : ((cnt >= 3'd4) ? 3'd4 : 3'd0);

    always_comb begin
        for (int i = 0; i < 4; i++)
            out_data[31-8*i -: 8] = (3'(i) < cnt) ? acc[i] : 8'h00;
    end

    assign pop      = out_valid & out_ready;
    // A word is only taken when all four of its bytes are guaranteed to fit.
    assign in_ready = !flush & ((cnt <= 3'd3) | ((cnt >= 3'd4) & pop));
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < 7; i++) acc_n[i] = acc[i];
        cnt_n = cnt;
        if (pop) begin
            if (out_last) begin
                for (int i = 0; i < 7; i++) acc_n[i] = 8'h00;
                cnt_n = 3'd0;
            end else begin
                acc_n[0] = acc[4];
                acc_n[1] = acc[5];
                acc_n[2] = acc[6];
                for (int i = 3; i < 7; i++) acc_n[i] = 8'h00;
                cnt_n = cnt - 3'd4;
            end
        end
        if (accept) begin
            for (int i = 0; i < 4; i++)
                if (3'(i) < fwd_cnt) acc_n[cnt_n + 3'(i)] = fwd[i];
            cnt_n = cnt_n + fwd_cnt;
        end
    end

    assign stuff_sum  = {1'b0, stuff_cnt} + (STUFF_CNT_W + 1)'(drop_cnt);
    assign stuff_next = stuff_sum[STUFF_CNT_W] ? {STUFF_CNT_W{1'b1}} : stuff_sum[STUFF_CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 7; i++) acc[i] <= 8'h00;
            cnt        <= 3'd0;
            flush      <= 1'b0;
            prev_ff    <= 1'b0;
            marker_det <= 1'b0;
            stuff_cnt  <= '0;
        end else begin
            for (int i = 0; i < 7; i++) acc[i] <= acc_n[i];
            cnt        <= cnt_n;
            marker_det <= accept & marker_hit;
            if (accept) begin
                prev_ff   <= prev_ff_next;
                stuff_cnt <= stuff_next;
                if (in_last) flush <= 1'b1;
            end else if (pop && out_last) begin
                flush   <= 1'b0;
                prev_ff <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ff_unstuffer.sv
// Bench for ff_unstuffer: directed stream scenarios plus randomized streams
// checked against a byte-queue reference model.
module tb_ff_unstuffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [2:0]  in_nbytes = '0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_nbytes;
    logic        out_ready = 1'b1;
    logic        marker_det;
    logic [15:0] stuff_cnt;

    ff_unstuffer #(.STUFF_CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_nbytes(in_nbytes),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_nbytes(out_nbytes),
        .out_ready(out_ready),
        .marker_det(marker_det), .stuff_cnt(stuff_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_stuff = 0;
    int marker_pulses = 0;
    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];
    logic [31:0] st_d[$];
    logic        st_l[$];
    logic [2:0]  st_n[$];

    // Output monitor: records {last, nbytes, data} for every output transfer.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got_q.push_back({out_last, out_nbytes, out_data});
        if (rst && marker_det) marker_pulses++;
    end

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n, output bit ok);
        in_data = d; in_last = l; in_nbytes = n; in_valid = 1'b1; ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; in_nbytes = 3'd0;
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 8'hFF;
        if (r < 6) return 8'h00;
        if (r == 6) return 8'hD9;
        return 8'($urandom_range(0, 255));
    endfunction

    // Reference: filter the stream byte by byte, then cut it into words. Words
    // before the last input word are only ever full; the flush then emits full
    // words while more than four bytes remain and a final 0..4 byte word.
    task automatic model_stream(inout int drops, inout int markers);
        logic [7:0]  fq[$];
        logic        prev;
        logic        mk;
        logic [7:0]  v;
        logic [31:0] d;
        int          n;
        int          k;
        prev = 1'b0;
        for (int w = 0; w < st_d.size(); w++) begin
            n = st_l[w] ? int'(st_n[w]) : 4;
            d = st_d[w];
            mk = 1'b0;
            for (int b = 0; b < n; b++) begin
                v = d[31-8*b -: 8];
                if (prev && v == 8'h00) begin
                    drops++;
                    prev = 1'b0;
                end else begin
                    if (prev && v != 8'hFF) mk = 1'b1;
                    fq.push_back(v);
                    prev = (v == 8'hFF);
                end
            end
            if (mk) markers++;
            while (fq.size() > (st_l[w] ? 4 : 3)) begin
                d = '0;
                for (int j = 0; j < 4; j++) d[31-8*j -: 8] = fq.pop_front();
                exp_q.push_back({1'b0, 3'd4, d});
            end
            if (st_l[w]) begin
                d = '0;
                k = fq.size();
                for (int j = 0; j < k; j++) d[31-8*j -: 8] = fq.pop_front();
                exp_q.push_back({1'b1, 3'(k), d});
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) begin @(posedge clk); #1; end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (out_nbytes !== 3'd0) begin bad++; $display("FAIL reset_out_nbytes got=%0d want=0", out_nbytes); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (marker_det !== 1'b0) begin bad++; $display("FAIL reset_marker got=%b want=0", marker_det); end
        total++; if (stuff_cnt !== 16'd0) begin bad++; $display("FAIL reset_stuff_cnt got=%0d want=0", stuff_cnt); end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_intra_word();
        bit ok;
        logic [35:0] e;
        got_q.delete(); out_ready = 1'b1;
        send_word(32'h12FF0034, 1'b1, 3'd4, ok);
        total++; if (!ok) begin bad++; $display("FAIL intra_accept timeout"); end
        wait_outputs(1, ok);
        exp_stuff += 1;
        e = {1'b1, 3'd3, 32'h12FF3400};
        total++; if (got_q.size() != 1 || got_q[0] !== e) begin bad++; $display("FAIL intra_out got_n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 36'hx, e); end
        total++; if (stuff_cnt !== 16'(exp_stuff)) begin bad++; $display("FAIL intra_stuff got=%0d want=%0d", stuff_cnt, exp_stuff); end
    endtask

    task automatic test_cross_word();
        bit ok;
        logic [35:0] e[2];
        got_q.delete(); out_ready = 1'b1;
        send_word(32'h000000FF, 1'b0, 3'd4, ok);
        send_word(32'h00ABCDEF, 1'b1, 3'd4, ok);
        wait_outputs(2, ok);
        exp_stuff += 1;
        e[0] = {1'b0, 3'd4, 32'h000000FF};
        e[1] = {1'b1, 3'd3, 32'hABCDEF00};
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL cross_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== e[i]) begin bad++; $display("FAIL cross_word%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 36'hx, e[i]); end
        end
        total++; if (stuff_cnt !== 16'(exp_stuff)) begin bad++; $display("FAIL cross_stuff got=%0d want=%0d", stuff_cnt, exp_stuff); end
    endtask

    task automatic test_fill_marker();
        bit ok;
        int m0;
        logic [35:0] e[2];
        got_q.delete(); out_ready = 1'b1; m0 = marker_pulses;
        send_word(32'hFFFF0011, 1'b0, 3'd4, ok);
        total++; if (marker_det !== 1'b0) begin bad++; $display("FAIL fill_no_marker got=%b want=0", marker_det); end
        send_word(32'hFFD90000, 1'b1, 3'd2, ok);
        total++; if (marker_det !== 1'b1) begin bad++; $display("FAIL marker_pulse got=%b want=1", marker_det); end
        @(posedge clk); #1;
        total++; if (marker_det !== 1'b0) begin bad++; $display("FAIL marker_not_sticky got=%b want=0", marker_det); end
        wait_outputs(2, ok);
        exp_stuff += 1;
        e[0] = {1'b0, 3'd4, 32'hFFFF11FF};
        e[1] = {1'b1, 3'd1, 32'hD9000000};
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL fill_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== e[i]) begin bad++; $display("FAIL fill_word%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 36'hx, e[i]); end
        end
        total++; if (marker_pulses - m0 != 1) begin bad++; $display("FAIL marker_count got=%0d want=1", marker_pulses - m0); end
        total++; if (stuff_cnt !== 16'(exp_stuff)) begin bad++; $display("FAIL fill_stuff got=%0d want=%0d", stuff_cnt, exp_stuff); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] w[5];
        w = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
        got_q.delete(); out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send_word(w[i], i == 4, 3'd4, ok);
                    total++; if (!ok) begin bad++; $display("FAIL bp_accept%0d timeout", i); end
                end
            end
            begin
                for (int c = 0; c < 6; c++) begin
                    @(posedge clk); #1;
                    if (c >= 1) begin
                        total++;
                        if (out_valid !== 1'b1 || out_data !== 32'h01020304 || in_ready !== 1'b0 || out_nbytes !== 3'd4) begin
                            bad++; $display("FAIL bp_stall c=%0d got valid=%b data=%h in_ready=%b nb=%0d want 1 01020304 0 4", c, out_valid, out_data, in_ready, out_nbytes);
                        end
                    end
                end
                out_ready = 1'b1;
            end
        join
        wait_outputs(5, ok);
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== {i == 4, 3'd4, w[i]}) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 36'hx, {i == 4, 3'd4, w[i]}); end
        end
    endtask

    task automatic test_empty_final();
        bit ok;
        logic [35:0] e[2];
        got_q.delete(); out_ready = 1'b1;
        send_word(32'hAABBCCFF, 1'b0, 3'd4, ok);
        send_word(32'h00000000, 1'b1, 3'd1, ok);
        wait_outputs(2, ok);
        exp_stuff += 1;
        e[0] = {1'b0, 3'd4, 32'hAABBCCFF};
        e[1] = {1'b1, 3'd0, 32'h00000000};
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL empty_count got=%0d want=2", got_q.size()); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== e[i]) begin bad++; $display("FAIL empty_word%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 36'hx, e[i]); end
        end
        total++; if (stuff_cnt !== 16'(exp_stuff)) begin bad++; $display("FAIL empty_stuff got=%0d want=%0d", stuff_cnt, exp_stuff); end
    endtask

    task automatic test_random();
        bit ok;
        bit stop;
        int drops;
        int markers;
        int m0;
        logic [31:0] d;
        got_q.delete(); exp_q.delete();
        drops = 0; markers = 0; m0 = marker_pulses; stop = 1'b0;
        fork
            begin
                for (int s = 0; s < 20; s++) begin
                    st_d.delete(); st_l.delete(); st_n.delete();
                    for (int w = $urandom_range(1, 6); w > 0; w--) begin
                        for (int b = 0; b < 4; b++) d[31-8*b -: 8] = rand_byte();
                        st_d.push_back(d);
                        st_l.push_back(w == 1);
                        st_n.push_back((w == 1) ? 3'($urandom_range(1, 4)) : 3'd4);
                    end
                    model_stream(drops, markers);
                    for (int w = 0; w < st_d.size(); w++) begin
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        send_word(st_d[w], st_l[w], st_n[w], ok);
                        if (!ok) begin total++; bad++; $display("FAIL rand_accept s=%0d w=%0d timeout", s, w); end
                    end
                end
                wait_outputs(exp_q.size(), ok);
                total++; if (!ok) begin bad++; $display("FAIL rand_drain got=%0d want=%0d", got_q.size(), exp_q.size()); end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        exp_stuff += drops;
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 36'hx, exp_q[i]); end
        end
        total++; if (marker_pulses - m0 != markers) begin bad++; $display("FAIL rand_markers got=%0d want=%0d", marker_pulses - m0, markers); end
        total++; if (stuff_cnt !== 16'(exp_stuff)) begin bad++; $display("FAIL rand_stuff got=%0d want=%0d", stuff_cnt, exp_stuff); end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        logic [35:0] e;
        got_q.delete(); out_ready = 1'b1;
        // Leaves three bytes (FF 11 FF) buffered with the FF-pending flag set.
        send_word(32'hFF0011FF, 1'b0, 3'd4, ok);
        total++; if (out_data !== 32'hFF11FF00) begin bad++; $display("FAIL mid_pre_data got=%h want=FF11FF00", out_data); end
        #2 rst = 1'b0;
        #1;
        exp_stuff = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        total++; if (stuff_cnt !== 16'd0) begin bad++; $display("FAIL mid_stuff got=%0d want=0", stuff_cnt); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_out_data got=%h want=0", out_data); end
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        got_q.delete();
        send_word(32'h00112233, 1'b1, 3'd4, ok);
        wait_outputs(1, ok);
        e = {1'b1, 3'd4, 32'h00112233};
        total++; if (got_q.size() != 1 || got_q[0] !== e) begin bad++; $display("FAIL mid_after got_n=%0d got=%h want=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 36'hx, e); end
        total++; if (stuff_cnt !== 16'd0) begin bad++; $display("FAIL mid_after_stuff got=%0d want=0", stuff_cnt); end
    endtask

    initial begin
        test_reset();
        test_intra_word();
        test_cross_word();
        test_fill_marker();
        test_backpressure();
        test_empty_final();
        test_random();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
